// File: rtl/keccak_squeeze_stream.sv
// SHAKE128/SHAKE256 squeeze stage: streams rate lanes of the Keccak state as
// output words and calls an external Keccak-f[1600] core when the rate is used up.
module keccak_squeeze_stream #(
  parameter int STATE_WIDTH = 1600,
  parameter int WORD_W      = 64,
  parameter int LEN_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [LEN_W-1:0]       out_words,
  input  logic [STATE_WIDTH-1:0] state_in,
  output logic                   perm_start,
  output logic [STATE_WIDTH-1:0] perm_state,
  input  logic                   perm_done,
  input  logic [STATE_WIDTH-1:0] perm_result,
  output logic [WORD_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int LANES_256 = 1088 / WORD_W;
  localparam int LANES_128 = 1344 / WORD_W;
  localparam int IDX_W     = $clog2(LANES_128 + 1);

  typedef enum logic [2:0] {IDLE, EMIT, PERM_REQ, PERM_WAIT, FIN} fsm_t;

  fsm_t                   fsm_q, fsm_d;
  logic                   mode_q, mode_d;
  logic [STATE_WIDTH-1:0] state_reg_q, state_reg_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [IDX_W-1:0]       lane_idx_q, lane_idx_d;
  logic [IDX_W-1:0]       last_lane;

  assign last_lane  = mode_q ? IDX_W'(LANES_128 - 1) : IDX_W'(LANES_256 - 1);
  assign perm_state = state_reg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= IDLE;
      mode_q      <= 1'b0;
      state_reg_q <= '0;
      remaining_q <= '0;
      lane_idx_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      mode_q      <= mode_d;
      state_reg_q <= state_reg_d;
      remaining_q <= remaining_d;
      lane_idx_q  <= lane_idx_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    mode_d      = mode_q;
    state_reg_d = state_reg_q;
    remaining_d = remaining_q;
    lane_idx_d  = lane_idx_q;
    perm_start  = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    done        = 1'b0;
    busy        = (fsm_q != IDLE);

    case (fsm_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          state_reg_d = state_in;
          remaining_d = out_words;
          lane_idx_d  = '0;
          fsm_d       = (out_words == '0) ? FIN : EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = state_reg_q[WORD_W*lane_idx_q +: WORD_W];
        out_last  = (remaining_q == LEN_W'(1));
        if (out_ready) begin
          remaining_d = remaining_q - LEN_W'(1);
          lane_idx_d  = lane_idx_q + IDX_W'(1);
          // The final word never triggers a permutation, even at the end of the rate.
          if (remaining_q == LEN_W'(1)) begin
            fsm_d = FIN;
          end else if (lane_idx_q == last_lane) begin
            fsm_d = PERM_REQ;
          end
        end
      end
      PERM_REQ: begin
        perm_start = 1'b1;
        fsm_d      = PERM_WAIT;
      end
      PERM_WAIT: begin
        if (perm_done) begin
          state_reg_d = perm_result;
          lane_idx_d  = '0;
          fsm_d       = EMIT;
        end
      end
      FIN: begin
        done  = 1'b1;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keccak_squeeze_stream.sv
// Scoreboard bench for keccak_squeeze_stream: a word-level model fills the
// expected queues, a monitor and a permutation stub check what the DUT emits.
module tb_keccak_squeeze_stream;

  localparam int SW     = 1600;
  localparam int WW     = 64;
  localparam int LW     = 16;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [LW-1:0] out_words;
  logic [SW-1:0] state_in;
  logic          perm_start;
  logic [SW-1:0] perm_state;
  logic          perm_done;
  logic [SW-1:0] perm_result;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  typedef struct {
    logic [WW-1:0] data;
    logic          last;
  } exp_word_t;

  exp_word_t     exp_q[$];
  logic [SW-1:0] perm_q[$];
  int compared      = 0;
  int mismatched    = 0;
  int perm_count    = 0;
  int perm_expected = 0;
  bit ready_rand    = 1'b0;
  int perm_delay    = 1;
  int stub_kind     = 1;

  keccak_squeeze_stream #(.STATE_WIDTH(SW), .WORD_W(WW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .out_words(out_words),
    .state_in(state_in), .perm_start(perm_start), .perm_state(perm_state),
    .perm_done(perm_done), .perm_result(perm_result), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      for (int i = 0; i < 25; i++) begin
        if (act[64*i +: 64] !== exp[64*i +: 64]) begin
          $display("[TB] FAIL %s: lane %0d got %h expected %h", name, i, act[64*i +: 64], exp[64*i +: 64]);
          break;
        end
      end
    end
  endtask

  // Stand-in permutation: kind 0 returns lanes 100+i, kind 1 a lane rotation with a constant mask.
  function automatic logic [SW-1:0] model_perm(input int kind, input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = '0;
    if (kind == 0) begin
      for (int i = 0; i < 25; i++) r[64*i +: 64] = 64'(100 + i);
    end else begin
      r = {s[SW-65:0], s[SW-1:SW-64]} ^ {25{64'h9E3779B97F4A7C15}};
    end
    return r;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] r;
    for (int i = 0; i < SW/32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Word k of the XOF output is lane k%rate of the state after k/rate permutations.
  task automatic build_model(input bit m, input int n, input logic [SW-1:0] st, input int kind);
    int rl;
    logic [SW-1:0] cur;
    exp_word_t e;
    rl  = m ? 21 : 17;
    cur = st;
    perm_expected = 0;
    perm_count    = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0 && (k % rl) == 0) begin
        perm_q.push_back(cur);
        perm_expected++;
        cur = model_perm(kind, cur);
      end
      e.data = cur[64*(k % rl) +: 64];
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    perm_q.delete();
    perm_expected = 0;
    perm_count    = 0;
  endtask

  task automatic apply_stimulus(input bit m, input int n, input logic [SW-1:0] st, input bit rr,
                                input int d, input int kind, input bit poke, input bit timed);
    int k;
    bit done_seen;
    int exp_done;
    ready_rand = rr;
    perm_delay = d;
    stub_kind  = kind;
    build_model(m, n, st, kind);
    exp_done  = (n == 0) ? 1 : n + 1 + perm_expected * (d + 1);
    start     = 1'b1;
    mode      = m;
    out_words = LW'(n);
    state_in  = st;
    k         = 0;
    done_seen = 1'b0;
    while (!done_seen && k < BUDGET) begin
      @(posedge clk); #1;
      start = poke && (k == 3);
      if (start) begin
        mode      = ~m;
        out_words = LW'($urandom_range(1, 60));
        state_in  = rand_state();
      end else begin
        state_in  = rand_state();
      end
      k++;
      @(negedge clk);
      if (k == 1) check_output("first_valid_latency", 64'(out_valid), 64'(n != 0));
      if (done) done_seen = 1'b1;
    end
    if (!done_seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles expected done", BUDGET);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      flush_model();
    end else if (timed) begin
      check_output("done_cycle", 64'(k), 64'(exp_done));
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_in_perm_wait();
    int k;
    logic [SW-1:0] st;
    st = rand_state();
    ready_rand = 1'b0;
    perm_delay = 6;
    stub_kind  = 1;
    build_model(1'b0, 30, st, 1);
    start     = 1'b1;
    mode      = 1'b0;
    out_words = LW'(30);
    state_in  = st;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < BUDGET) begin
      @(negedge clk);
      if (perm_start) break;
      k++;
    end
    check_output("perm_start_seen", 64'(k < BUDGET), 64'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_output("reset_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    flush_model();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("post_reset_quiet", {62'b0, out_valid, busy}, 64'(0));
    end
    @(posedge clk); #1;
    apply_stimulus(1'b0, 3, rand_state(), 1'b0, 1, 1, 1'b0, 1'b1);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic [SW-1:0] snap;
    perm_done   = 1'b0;
    perm_result = '0;
    forever begin
      @(negedge clk);
      if (perm_start && !reset) begin
        if (perm_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL perm_unexpected: got perm_start expected none");
        end else begin
          check_state("perm_state", perm_state, perm_q.pop_front());
        end
        perm_count++;
        snap = perm_state;
        repeat (perm_delay) @(posedge clk);
        #1;
        perm_result = model_perm(stub_kind, snap);
        perm_done   = 1'b1;
        @(posedge clk); #1;
        perm_done   = 1'b0;
        perm_result = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks handshake rules.
  initial begin
    bit prev_stall, prev_done, prev_ps;
    logic [WW-1:0] prev_data;
    logic prev_last;
    exp_word_t e;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_ps    = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check_output("reset_ctrl", {59'b0, out_valid, out_last, busy, done, perm_start}, 64'(0));
        check_output("reset_data", out_data, 64'(0));
        check_state("reset_perm_state", perm_state, '0);
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_ps    = 1'b0;
      end else begin
        if (prev_stall) begin
          check_output("stall_valid", 64'(out_valid), 64'(1));
          check_output("stall_data", out_data, prev_data);
          check_output("stall_last", 64'(out_last), 64'(prev_last));
        end
        if (!out_valid) check_output("idle_data_zero", out_data, 64'(0));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_word: got %h expected no word", out_data);
          end else begin
            e = exp_q.pop_front();
            check_output("word_data", out_data, e.data);
            check_output("word_last", 64'(out_last), 64'(e.last));
          end
        end
        if (done) begin
          check_output("done_queue_empty", 64'(exp_q.size()), 64'(0));
          check_output("perm_count", 64'(perm_count), 64'(perm_expected));
          check_output("done_one_cycle", 64'(prev_done), 64'(0));
        end
        if (perm_start) check_output("perm_start_one_cycle", 64'(prev_ps), 64'(0));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_done  = done;
        prev_ps    = perm_start;
      end
    end
  end

  initial begin
    logic [SW-1:0] st;
    bit m, rr, poke;
    int n, d;
    reset     = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    out_words = '0;
    state_in  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++) st[64*i +: 64] = 64'(i + 1);
    $display("[TB] four words, no permutation");
    apply_stimulus(1'b0, 4, st, 1'b0, 1, 1, 1'b0, 1'b1);
    $display("[TB] 18 words across one permutation");
    apply_stimulus(1'b0, 18, st, 1'b0, 5, 0, 1'b0, 1'b1);
    $display("[TB] SHAKE128, 43 words");
    apply_stimulus(1'b1, 43, rand_state(), 1'b0, 3, 1, 1'b0, 1'b1);
    $display("[TB] 40 words with stalls");
    apply_stimulus(1'b0, 40, st, 1'b1, 2, 1, 1'b0, 1'b0);
    $display("[TB] zero words and start while busy");
    apply_stimulus(1'b0, 0, rand_state(), 1'b0, 1, 1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 30, rand_state(), 1'b1, 4, 1, 1'b1, 1'b0);
    $display("[TB] reset during permutation wait");
    reset_in_perm_wait();

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      m    = 1'($urandom_range(0, 1));
      n    = $urandom_range(0, 70);
      rr   = 1'($urandom_range(0, 1));
      d    = $urandom_range(1, 6);
      poke = (n >= 30) && ($urandom_range(0, 1) == 1);
      apply_stimulus(m, n, rand_state(), rr, d, 1, poke, !rr);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
